// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_pkg: shared funct3 codes, sequencer states, legality helper   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } dmem_state_t;

  // Unsigned variants only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_lane_align: byte-lane enables, store replication, load extend |
// | and fault decode. Purely combinational. Rev 1.0                    |
// +--------------------------------------------------------------------+
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_Funct3,
  input  logic        i_WE,
  input  logic [1:0]  i_Lane,
  input  logic [31:0] i_WD,
  input  logic [31:0] i_Raw,
  output logic [3:0]  o_BE,
  output logic [31:0] o_WData,
  output logic [31:0] o_RD,
  output logic        o_Misaligned,
  output logic        o_Illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_Raw[7:0];
    case (i_Lane)
      2'd1:    w_byte = i_Raw[15:8];
      2'd2:    w_byte = i_Raw[23:16];
      2'd3:    w_byte = i_Raw[31:24];
      default: w_byte = i_Raw[7:0];
    endcase
    w_half = i_Lane[1] ? i_Raw[31:16] : i_Raw[15:0];
  end

  // Store data is replicated across lanes so the enables alone pick the target.
  always_comb begin
    o_Illegal    = ~f3_legal(i_Funct3, i_WE);
    o_Misaligned = 1'b0;
    o_BE         = 4'b0000;
    o_WData      = i_WD;
    o_RD         = i_Raw;
    case (i_Funct3)
      F3_B, F3_BU: begin
        o_BE    = 4'b0001 << i_Lane;
        o_WData = {4{i_WD[7:0]}};
        o_RD    = i_Funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      F3_H, F3_HU: begin
        o_Misaligned = i_Lane[0];
        o_BE         = i_Lane[1] ? 4'b1100 : 4'b0011;
        o_WData      = {2{i_WD[15:0]}};
        o_RD         = i_Funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      F3_W: begin
        o_Misaligned = |i_Lane;
        o_BE         = 4'b1111;
      end
      default: begin
        o_BE = 4'b0000;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_byte_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_byte_ctrl: byte-addressed RISC-V data memory with zero-fill   |
// | sequencer and optional registered read. Rev 1.0                    |
// +--------------------------------------------------------------------+
module dmem_byte_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter bit INIT_ON_RESET = 1'b1,
  parameter bit READ_REG      = 1'b0
) (
  input  logic              i_CLK,
  input  logic              i_Reset,
  input  logic              i_Req,
  input  logic              i_WE,
  input  logic [2:0]        i_Funct3,
  input  logic [ADDR_W-1:0] i_A,
  input  logic [31:0]       i_WD,
  output logic [31:0]       o_RD,
  output logic              o_RValid,
  output logic              o_Busy,
  output logic              o_Misaligned,
  output logic              o_Illegal
);

  localparam int c_IDX_W = ADDR_W - 2;
  localparam int c_DEPTH = 2 ** c_IDX_W;
  localparam logic [c_IDX_W-1:0] c_LAST = '1;

  dmem_state_t        r_state;
  dmem_state_t        w_state_next;
  logic [c_IDX_W-1:0] r_ptr;
  logic [31:0]        r_mem [c_DEPTH];

  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_raw;
  logic [31:0]        w_wdata;
  logic [31:0]        w_ext;
  logic [3:0]         w_be;
  logic               w_mis;
  logic               w_ill;
  logic               w_busy;
  logic               w_active;
  logic               w_store;
  logic               w_load;

  assign w_idx    = i_A[ADDR_W-1:2];
  assign w_raw    = r_mem[w_idx];
  assign w_busy   = (r_state == ST_INIT);
  assign w_active = i_Req & ~w_busy;
  assign w_store  = w_active & i_WE & ~(w_mis | w_ill) & ~i_Reset;
  assign w_load   = w_active & ~i_WE & ~(w_mis | w_ill);

  assign o_Busy       = w_busy;
  assign o_Misaligned = w_active & w_mis;
  assign o_Illegal    = w_active & w_ill;

  dmem_lane_align u_align (
    .i_Funct3     (i_Funct3),
    .i_WE         (i_WE),
    .i_Lane       (i_A[1:0]),
    .i_WD         (i_WD),
    .i_Raw        (w_raw),
    .o_BE         (w_be),
    .o_WData      (w_wdata),
    .o_RD         (w_ext),
    .o_Misaligned (w_mis),
    .o_Illegal    (w_ill)
  );

  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      r_state <= INIT_ON_RESET ? ST_INIT : ST_READY;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_busy) r_ptr <= r_ptr + {{(c_IDX_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT:  if (r_ptr == c_LAST) w_state_next = ST_READY;
      default:  w_state_next = ST_READY;
    endcase
  end

  // No reset on the array: contents survive reset when zero-fill is disabled.
  always_ff @(posedge i_CLK) begin
    if (w_busy) begin
      r_mem[r_ptr] <= '0;
    end else if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  if (READ_REG) begin : g_read_reg
    logic [31:0] r_rd;
    logic        r_rvalid;

    always_ff @(posedge i_CLK) begin
      if (i_Reset) begin
        r_rd     <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_load;
        if (w_load) r_rd <= w_ext;
      end
    end

    assign o_RD     = r_rd;
    assign o_RValid = r_rvalid;
  end else begin : g_read_comb
    assign o_RD     = w_ext;
    assign o_RValid = w_load;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_byte_ctrl.sv
`default_nettype none
// Bench for dmem_byte_ctrl: combinational-read and registered-read instances
// share one stimulus stream; ADDR_W=6 gives 16 words.
module tb_dmem_byte_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  f3;
  logic [5:0]  a;
  logic [31:0] wd;
  logic [31:0] rd_c, rd_r;
  logic        rv_c, rv_r, busy_c, busy_r, mis_c, mis_r, ill_c, ill_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_byte_ctrl #(.ADDR_W(6), .INIT_ON_RESET(1'b1), .READ_REG(1'b0)) dut_c (
    .i_CLK(clk), .i_Reset(rst), .i_Req(req), .i_WE(we), .i_Funct3(f3),
    .i_A(a), .i_WD(wd), .o_RD(rd_c), .o_RValid(rv_c), .o_Busy(busy_c),
    .o_Misaligned(mis_c), .o_Illegal(ill_c)
  );

  dmem_byte_ctrl #(.ADDR_W(6), .INIT_ON_RESET(1'b1), .READ_REG(1'b1)) dut_r (
    .i_CLK(clk), .i_Reset(rst), .i_Req(req), .i_WE(we), .i_Funct3(f3),
    .i_A(a), .i_WD(wd), .o_RD(rd_r), .o_RValid(rv_r), .o_Busy(busy_r),
    .o_Misaligned(mis_r), .o_Illegal(ill_r)
  );

  typedef struct {
    string       name;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [5:0]  a;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] rd;
    logic        rv;
    logic        mis;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic r, input logic w,
                              input logic [2:0] f, input logic [5:0] ad,
                              input logic [31:0] d, input logic c,
                              input logic [31:0] e, input logic v,
                              input logic m, input logic il);
    vec_t t;
    t.name = n; t.req = r; t.we = w; t.f3 = f; t.a = ad; t.wd = d;
    t.chk_rd = c; t.rd = e; t.rv = v; t.mis = m; t.ill = il;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles starting from the current one; drops req as soon as busy ends.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_c && n < 40) begin
      n++;
      step();
    end
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;

    vecs.push_back(mk("lw0_after_init", 1, 0, F3_W,  6'h00, 32'h0,        1, 32'h00000000, 1, 0, 0));
    vecs.push_back(mk("sw0",            1, 1, F3_W,  6'h00, 32'h87654321, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk("lb3",            1, 0, F3_B,  6'h03, 32'h0,        1, 32'hFFFFFF87, 1, 0, 0));
    vecs.push_back(mk("lbu3",           1, 0, F3_BU, 6'h03, 32'h0,        1, 32'h00000087, 1, 0, 0));
    vecs.push_back(mk("lh2",            1, 0, F3_H,  6'h02, 32'h0,        1, 32'hFFFF8765, 1, 0, 0));
    vecs.push_back(mk("lhu0",           1, 0, F3_HU, 6'h00, 32'h0,        1, 32'h00004321, 1, 0, 0));
    vecs.push_back(mk("lb0",            1, 0, F3_B,  6'h00, 32'h0,        1, 32'h00000021, 1, 0, 0));
    vecs.push_back(mk("sw4",            1, 1, F3_W,  6'h04, 32'h11223344, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk("sb5",            1, 1, F3_B,  6'h05, 32'h000055AB, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk("lw4_after_sb",   1, 0, F3_W,  6'h04, 32'h0,        1, 32'h1122AB44, 1, 0, 0));
    vecs.push_back(mk("sh6",            1, 1, F3_H,  6'h06, 32'h0000BEEF, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk("lw4_after_sh",   1, 0, F3_W,  6'h04, 32'h0,        1, 32'hBEEFAB44, 1, 0, 0));
    vecs.push_back(mk("lh6",            1, 0, F3_H,  6'h06, 32'h0,        1, 32'hFFFFBEEF, 1, 0, 0));
    vecs.push_back(mk("lhu4",           1, 0, F3_HU, 6'h04, 32'h0,        1, 32'h0000AB44, 1, 0, 0));
    vecs.push_back(mk("sw8",            1, 1, F3_W,  6'h08, 32'hA5A5A5A5, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk("sw9_mis",        1, 1, F3_W,  6'h09, 32'hFFFFFFFF, 0, 32'h0,        0, 1, 0));
    vecs.push_back(mk("lw8_unchanged",  1, 0, F3_W,  6'h08, 32'h0,        1, 32'hA5A5A5A5, 1, 0, 0));
    vecs.push_back(mk("lh1_mis",        1, 0, F3_H,  6'h01, 32'h0,        0, 32'h0,        0, 1, 0));
    vecs.push_back(mk("lw2_mis",        1, 0, F3_W,  6'h02, 32'h0,        0, 32'h0,        0, 1, 0));
    vecs.push_back(mk("ld_f3_011",      1, 0, 3'b011, 6'h00, 32'h0,       0, 32'h0,        0, 0, 1));
    vecs.push_back(mk("swC",            1, 1, F3_W,  6'h0C, 32'h12345678, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk("st_f3_100_ill",  1, 1, F3_BU, 6'h0C, 32'h000000FF, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk("st_f3_110_ill",  1, 1, 3'b110, 6'h0C, 32'h0,       0, 32'h0,        0, 0, 1));
    vecs.push_back(mk("lwC_unchanged",  1, 0, F3_W,  6'h0C, 32'h0,        1, 32'h12345678, 1, 0, 0));
    vecs.push_back(mk("lw3C_top_word",  1, 0, F3_W,  6'h3C, 32'h0,        1, 32'h00000000, 1, 0, 0));
    vecs.push_back(mk("idle_no_valid",  0, 0, F3_W,  6'h04, 32'h0,        0, 32'h0,        0, 0, 0));
    vecs.push_back(mk("idle_mis_gated", 0, 0, F3_H,  6'h01, 32'h0,        0, 32'h0,        0, 0, 0));

    // Reset held 3 cycles
    rst = 1'b1; req = 1'b0; we = 1'b0; f3 = F3_W; a = '0; wd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy_c}, 32'h1);
    chk("rst_rvalid_reg", {31'h0, rv_r}, 32'h0);
    chk("rst_rd_reg", rd_r, 32'h0);

    // Store attempted throughout INIT must be ignored
    rst = 1'b0;
    req = 1'b1; we = 1'b1; f3 = F3_W; a = 6'h00; wd = 32'hDEADBEEF;
    #1;
    chk("init_rvalid", {31'h0, rv_c}, 32'h0);
    chk("init_mis", {31'h0, mis_c}, 32'h0);
    chk("init_ill", {31'h0, ill_c}, 32'h0);
    count_busy(n);
    chk("init_busy_cycles", 32'(n), 32'd16);
    chk("init_busy_reg_inst", {31'h0, busy_r}, 32'h0);

    foreach (vecs[i]) begin
      req = vecs[i].req; we = vecs[i].we; f3 = vecs[i].f3;
      a = vecs[i].a; wd = vecs[i].wd;
      #4;
      if (vecs[i].chk_rd) chk($sformatf("%s.rd", vecs[i].name), rd_c, vecs[i].rd);
      chk($sformatf("%s.rvalid", vecs[i].name), {31'h0, rv_c}, {31'h0, vecs[i].rv});
      chk($sformatf("%s.mis", vecs[i].name), {31'h0, mis_c}, {31'h0, vecs[i].mis});
      chk($sformatf("%s.ill", vecs[i].name), {31'h0, ill_c}, {31'h0, vecs[i].ill});
      step();
    end
    req = 1'b0;

    // Registered read: store at n, load at n+1, data at n+2
    req = 1'b1; we = 1'b1; f3 = F3_W; a = 6'h3C; wd = 32'hCAFEF00D;
    step();
    we = 1'b0;
    chk("rr_n1_rvalid", {31'h0, rv_r}, 32'h0);
    #1;
    chk("comb_load_after_store", rd_c, 32'hCAFEF00D);
    step();
    req = 1'b0;
    chk("rr_n2_rvalid", {31'h0, rv_r}, 32'h1);
    chk("rr_n2_rd", rd_r, 32'hCAFEF00D);
    step();
    chk("rr_n3_rvalid", {31'h0, rv_r}, 32'h0);
    chk("rr_n3_rd_hold", rd_r, 32'hCAFEF00D);

    // Combinational read during a store edge sees the old word
    req = 1'b1; we = 1'b1; f3 = F3_W; a = 6'h3C; wd = 32'h01020304;
    #4;
    chk("comb_prestore_rd", rd_c, 32'hCAFEF00D);
    step();
    req = 1'b0; we = 1'b0;
    #1;
    chk("comb_poststore_rd", rd_c, 32'h01020304);
    step();

    // Reset mid-INIT at ptr=5 restarts the full zero-fill
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midinit_busy", {31'h0, busy_c}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n);
    chk("midinit_busy_cycles", 32'(n), 32'd16);
    for (int w = 0; w < 16; w++) begin
      req = 1'b1; we = 1'b0; f3 = F3_W; a = 6'(w * 4);
      #4;
      chk($sformatf("zero_word_%0d", w), rd_c, 32'h0);
      step();
    end
    req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
